nios_div_cell: RTL and testbench
================================

# nios_div_cell

Iterative radix-2 divider cell for the Nios integer datapath, the inverse counterpart of the pipelined multiply cell. Takes a dividend/divisor pair on a start pulse, runs one restoring-division step per clock, and returns quotient and remainder with a single-cycle done pulse. Sits beside the multiply cell in the M stage and serves div/divu/rem/remu instructions, stalling the pipeline via busy.

## Interface
- DATA_WIDTH, 32, operand/result width in bits; latency scales as DATA_WIDTH+2
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, synchronous, active-low
- M_div_src1  input  DATA_WIDTH  dividend, sampled on accepted start
- M_div_src2  input  DATA_WIDTH  divisor, sampled on accepted start
- M_div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accepted start
- M_div_start  input  1  request; accepted only in IDLE
- M_div_busy  output  1  high while a division is in progress
- M_div_done  output  1  one-cycle pulse, results valid
- M_div_quotient  output  DATA_WIDTH  quotient, held until next accepted start
- M_div_remainder  output  DATA_WIDTH  remainder, held until next accepted start
- M_div_by_zero  output  1  divisor was zero; valid/held with results

## Operation
- States: IDLE, CALC, FIX. Reset (reset_n low at an edge) forces IDLE, step counter 0, all outputs 0 — including mid-operation; in-flight division discarded, no done.
- IDLE: start high -> latch operands, signed flag; store magnitudes (|src| when signed and negative, else raw); record quotient sign = sign1 XOR sign2, remainder sign = sign1 (signed mode only); by_zero = (src2 == 0); partial remainder 0; counter = DATA_WIDTH-1; -> CALC. Quotient/remainder/by_zero outputs cleared on acceptance.
- CALC, per cycle: shift {partial remainder, dividend reg} left 1; trial = partial - divisor magnitude (DATA_WIDTH+1 bits); if non-negative, partial = trial and shift in quotient bit 1, else keep and shift in 0. Counter decrements; after step with counter 0 -> FIX.
- FIX: apply signs (negate quotient if quotient sign set, negate remainder if remainder sign set); by_zero overrides: quotient = all ones, remainder = original src1 (unsigned and signed). Register outputs, done = 1, -> IDLE.
- Signed overflow (-2^(W-1) / -1): quotient = 0x80000000, remainder 0, by_zero 0; falls out of magnitude path, no special case.
- Quotient truncates toward zero; remainder carries dividend's sign; |remainder| < |divisor|.
- start while busy (CALC/FIX): ignored, no effect on operands or outputs.
- Divide-by-zero runs full latency (no early exit).

## Timing
- start high in cycle N (IDLE) -> busy high cycles N+1..N+DATA_WIDTH+1; done high exactly in cycle N+DATA_WIDTH+2 (N+34 at W=32), busy low that cycle.
- Results and by_zero valid from done cycle, stable until next accepted start.
- Back-to-back: start may be asserted in the done cycle; accepted, busy rises next cycle; outputs clear next cycle.
- busy and done never high in the same cycle. busy reset value 0, done reset value 0.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Unsigned: src1=100, src2=7, signed=0 -> done at N+34, quotient 14, remainder 2, by_zero 0, busy high exactly 33 cycles.
- Signed mix: src1=-7 (0xFFFFFFF9), src2=2, signed=1 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); same operands signed=0 -> quotient 0x7FFFFFFC, remainder 1.
- Divide by zero: src1=0xFFFFFFF9, src2=0, signed=1 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFF9, by_zero 1, done still at N+34.
- Overflow: src1=0x80000000, src2=0xFFFFFFFF, signed=1 -> quotient 0x80000000, remainder 0.
- Start while busy: second start with different operands at N+10 ignored; first result correct, single done pulse; then start in the done cycle accepted -> second done at done+34.
- Reset mid-op: reset_n low for one edge at N+15 -> next cycle busy 0, done 0, outputs 0; no done pulse follows; fresh start afterwards completes normally.

Source files
------------

// File: rtl/nios_div_if.sv
// Divider request/result bundle between the M-stage control and the divide cell.
// Master drives operands and start; slave returns busy/done and the held results.
interface nios_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] M_div_src1;
    logic [DATA_WIDTH-1:0] M_div_src2;
    logic                  M_div_signed;
    logic                  M_div_start;
    logic                  M_div_busy;
    logic                  M_div_done;
    logic [DATA_WIDTH-1:0] M_div_quotient;
    logic [DATA_WIDTH-1:0] M_div_remainder;
    logic                  M_div_by_zero;

    modport master (
        output M_div_src1, M_div_src2, M_div_signed, M_div_start,
        input  M_div_busy, M_div_done, M_div_quotient, M_div_remainder, M_div_by_zero
    );

    modport slave (
        input  M_div_src1, M_div_src2, M_div_signed, M_div_start,
        output M_div_busy, M_div_done, M_div_quotient, M_div_remainder, M_div_by_zero
    );
endinterface

// File: rtl/nios_div_cell.sv
// Iterative restoring radix-2 divider (signed/unsigned), done DATA_WIDTH+2 cycles after start.
// No backpressure: start is taken only when idle; busy stalls the pipeline meanwhile.
module nios_div_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    nios_div_if.slave  div
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;

    logic [DATA_WIDTH-1:0] r_src1;
    logic [DATA_WIDTH-1:0] r_dvd;
    logic [DATA_WIDTH-1:0] r_dsr;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [CW-1:0]         r_cnt;
    logic                  r_qsign;
    logic                  r_rsign;
    logic                  r_bz_pend;

    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_quot;
    logic [DATA_WIDTH-1:0] r_remd;
    logic                  r_bz;

    logic                  w_neg1;
    logic                  w_neg2;
    logic [DATA_WIDTH-1:0] w_mag1;
    logic [DATA_WIDTH-1:0] w_mag2;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_qbit;

    assign w_neg1 = div.M_div_signed & div.M_div_src1[DATA_WIDTH-1];
    assign w_neg2 = div.M_div_signed & div.M_div_src2[DATA_WIDTH-1];
    assign w_mag1 = w_neg1 ? -div.M_div_src1 : div.M_div_src1;
    assign w_mag2 = w_neg2 ? -div.M_div_src2 : div.M_div_src2;

    // Partial remainder stays below the divisor, so bit DATA_WIDTH of the trial is the borrow.
    assign w_shift = {r_rem, r_dvd[DATA_WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dsr};
    assign w_qbit  = ~w_trial[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div.M_div_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_src1    <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_bz_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_remd    <= '0;
            r_bz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_src1    <= div.M_div_src1;
                        r_dvd     <= w_mag1;
                        r_dsr     <= w_mag2;
                        r_rem     <= '0;
                        r_cnt     <= CW'(DATA_WIDTH - 1);
                        r_qsign   <= w_neg1 ^ w_neg2;
                        r_rsign   <= w_neg1;
                        r_bz_pend <= (div.M_div_src2 == '0);
                        r_busy    <= 1'b1;
                        r_quot    <= '0;
                        r_remd    <= '0;
                        r_bz      <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_qbit ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
                    r_dvd <= {r_dvd[DATA_WIDTH-2:0], w_qbit};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    // Divide-by-zero result mirrors the architectural convention: all ones / dividend.
                    if (r_bz_pend) begin
                        r_quot <= '1;
                        r_remd <= r_src1;
                    end else begin
                        r_quot <= r_qsign ? -r_dvd : r_dvd;
                        r_remd <= r_rsign ? -r_rem : r_rem;
                    end
                    r_bz   <= r_bz_pend;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign div.M_div_busy      = r_busy;
    assign div.M_div_done      = r_done;
    assign div.M_div_quotient  = r_quot;
    assign div.M_div_remainder = r_remd;
    assign div.M_div_by_zero   = r_bz;
endmodule

// File: tb/tb_nios_div_cell.sv
// Scoreboard bench for nios_div_cell: directed corner cases then random operands
// checked against plain-arithmetic division with a cycle-accurate done deadline.
module tb_nios_div_cell;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_div_if #(.DATA_WIDTH(W)) bus ();

    nios_div_cell #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         bz;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   brun     = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic bz);
        longint sa, sb;
        if (b == 0) begin
            q  = '1;
            r  = a;
            bz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            bz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            bz = 1'b0;
        end
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (bus.M_div_busy) brun++;
            if (bus.M_div_done) begin
                check("done_expected", W'(exp_q.size() != 0), 1);
                check("busy_low_at_done", W'(bus.M_div_busy), 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("quotient", bus.M_div_quotient, e.q);
                    check("remainder", bus.M_div_remainder, e.r);
                    check("by_zero", W'(bus.M_div_by_zero), W'(e.bz));
                    check("done_cycle", W'(cyc), W'(e.due));
                    check("busy_cycles", W'(brun), W'(LAT - 1));
                end
                brun = 0;
            end else if (!bus.M_div_busy) begin
                brun = 0;
            end
        end else begin
            brun = 0;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        ref_div(a, b, s, e.q, e.r, e.bz);
        e.due = cyc + LAT;
        exp_q.push_back(e);
        bus.M_div_src1   = a;
        bus.M_div_src2   = b;
        bus.M_div_signed = s;
        bus.M_div_start  = 1'b1;
        @(negedge clk);
        bus.M_div_start  = 1'b0;
        bus.M_div_src1   = $urandom;
        bus.M_div_src2   = $urandom;
        bus.M_div_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < LAT + 20) begin
            @(negedge clk);
            k++;
        end
        check(name, W'(exp_q.size()), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, W'(bus.M_div_busy), 0);
        check({tag, "_done"}, W'(bus.M_div_done), 0);
        check({tag, "_quot"}, bus.M_div_quotient, 0);
        check({tag, "_rem"}, bus.M_div_remainder, 0);
        check({tag, "_bz"}, W'(bus.M_div_by_zero), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        int           k;
        bus.M_div_src1   = '0;
        bus.M_div_src2   = '0;
        bus.M_div_signed = 1'b0;
        bus.M_div_start  = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset_n = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7, 1'b0);           wait_idle("drain_unsigned");
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);     wait_idle("drain_signed_mix");
        issue(32'hFFFF_FFF9, 32'd2, 1'b0);     wait_idle("drain_unsigned_mix");
        issue(32'hFFFF_FFF9, 32'd0, 1'b1);     wait_idle("drain_div_zero");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle("drain_overflow");

        // Start while busy is ignored; then restart in the done cycle
        issue(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        bus.M_div_src1  = 32'd55;
        bus.M_div_src2  = 32'd4;
        bus.M_div_start = 1'b1;
        @(negedge clk);
        bus.M_div_start = 1'b0;
        k = 0;
        while (!bus.M_div_done && k < LAT + 10) begin
            @(negedge clk);
            k++;
        end
        check("first_done_seen", W'(bus.M_div_done), 1);
        issue(32'd77, 32'd5, 1'b0);
        check("restart_busy", W'(bus.M_div_busy), 1);
        check("restart_quot_clear", bus.M_div_quotient, 0);
        check("restart_done_clear", W'(bus.M_div_done), 0);
        wait_idle("drain_back_to_back");

        // Reset mid-operation discards the division
        issue(32'd12345, 32'd6, 1'b0);
        repeat (13) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_cleared("midreset");
        reset_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        check("no_done_after_reset", W'(bus.M_div_done), 0);
        issue(32'd12345, 32'd6, 1'b0);         wait_idle("drain_after_reset");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'd1;
                2:       b = '1;
                3:       b = W'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            issue(a, b, s);
            wait_idle("drain_random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
